// File: rtl/mmio_mem_responder_pkg.sv
// Shared types and default memory map for the tile MMIO responder.
package mmio_mem_responder_pkg;

    localparam int unsigned MMIO_ADRS_W = 32;
    localparam int unsigned MMIO_DATA_W = 32;
    localparam int unsigned MMIO_BE_W   = 4;
    localparam int unsigned MMIO_TAG_W  = 8;

    localparam logic [MMIO_ADRS_W-1:0] MMIO_I_MEM_BASE = 32'h0000_0000;
    localparam logic [MMIO_ADRS_W-1:0] MMIO_I_MEM_SIZE = 32'h0000_1000;
    localparam logic [MMIO_ADRS_W-1:0] MMIO_D_MEM_BASE = 32'h0040_0000;
    localparam logic [MMIO_ADRS_W-1:0] MMIO_D_MEM_SIZE = 32'h0000_2000;
    localparam int unsigned            MMIO_GNT_TIMEOUT = 64;

    // Responder sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_RESP   = 2'd3
    } t_mmio_rsp_state;

    // Latched request; adrs holds the offset within the selected memory.
    typedef struct packed {
        logic                   wr;
        logic [MMIO_ADRS_W-1:0] adrs;
        logic [MMIO_DATA_W-1:0] data;
        logic [MMIO_BE_W-1:0]   byteen;
        logic [MMIO_TAG_W-1:0]  tag;
    } t_mmio_req;

    // Response payload held for the response channel.
    typedef struct packed {
        logic [MMIO_DATA_W-1:0] data;
        logic [MMIO_TAG_W-1:0]  tag;
        logic                   err;
    } t_mmio_rsp;

    // Power-of-two window match: drop the in-window bits and compare to the base.
    function automatic logic win_hit(
        input logic [MMIO_ADRS_W-1:0] adrs,
        input logic [MMIO_ADRS_W-1:0] base,
        input logic [MMIO_ADRS_W-1:0] size
    );
        return (adrs & ~(size - 32'd1)) == base;
    endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational decode of an MMIO byte address into i_mem / d_mem windows.
module mmio_addr_decode
    import mmio_mem_responder_pkg::*;
#(
    parameter logic [31:0] I_MEM_BASE = MMIO_I_MEM_BASE,
    parameter logic [31:0] I_MEM_SIZE = MMIO_I_MEM_SIZE,
    parameter logic [31:0] D_MEM_BASE = MMIO_D_MEM_BASE,
    parameter logic [31:0] D_MEM_SIZE = MMIO_D_MEM_SIZE
) (
    input  logic [31:0] adrs,
    input  logic        wr,
    output logic        hit_i,
    output logic        hit_d,
    output logic [31:0] offset,
    output logic        err
);

    // Window match, offset and error; i_mem takes priority if windows ever overlap.
    always_comb begin
        hit_i  = win_hit(adrs, I_MEM_BASE, I_MEM_SIZE);
        hit_d  = win_hit(adrs, D_MEM_BASE, D_MEM_SIZE) & ~hit_i;
        offset = hit_i ? (adrs - I_MEM_BASE) : (adrs - D_MEM_BASE);
        // Reads must be word aligned; writes rely on byte enables instead.
        err    = ~(hit_i | hit_d) | (~wr & (adrs[1:0] != 2'b00));
    end

endmodule

// File: rtl/mmio_mem_responder.sv
// MMIO responder: one outstanding request, decoded to i_mem/d_mem, issued on arbiter grant.
module mmio_mem_responder
    import mmio_mem_responder_pkg::*;
#(
    parameter logic [31:0] I_MEM_BASE  = MMIO_I_MEM_BASE,
    parameter logic [31:0] I_MEM_SIZE  = MMIO_I_MEM_SIZE,
    parameter logic [31:0] D_MEM_BASE  = MMIO_D_MEM_BASE,
    parameter logic [31:0] D_MEM_SIZE  = MMIO_D_MEM_SIZE,
    parameter int unsigned GNT_TIMEOUT = MMIO_GNT_TIMEOUT
) (
    input  logic        QClk,
    input  logic        RstQnnnL,
    // request channel
    input  logic        ReqValidQ,
    output logic        ReqReadyQ,
    input  logic        ReqWrQ,
    input  logic [31:0] ReqAdrsQ,
    input  logic [31:0] ReqWrDataQ,
    input  logic [3:0]  ReqByteEnQ,
    input  logic [7:0]  ReqTagQ,
    // response channel
    output logic        RspValidQ,
    input  logic        RspReadyQ,
    output logic [31:0] RspDataQ,
    output logic [7:0]  RspTagQ,
    output logic        RspErrQ,
    // memory-side port
    output logic        MmioReqQ,
    input  logic        MemGntQ,
    output logic [31:0] MmioAdrsQ,
    output logic [31:0] MmioWrDataQ,
    output logic [3:0]  MmioByteEnQ,
    output logic        MmioDMemRdQ,
    output logic        MmioDMemWrQ,
    output logic        MmioIMemRdQ,
    output logic        MmioIMemWrQ,
    input  logic [31:0] DMemRdDataQ,
    input  logic [31:0] IMemRdDataQ
);

    localparam int unsigned      CNT_W    = (GNT_TIMEOUT > 2) ? $clog2(GNT_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GNT_TIMEOUT - 1);

    t_mmio_rsp_state  state_q, state_d;
    t_mmio_req        req_q, req_d;
    t_mmio_rsp        rsp_q, rsp_d;
    logic [1:0]       tgt_q, tgt_d;      // {d_mem, i_mem}
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             dec_hit_i;
    logic             dec_hit_d;
    logic             dec_err;
    logic [31:0]      dec_offset;
    logic             gnt_c;

    mmio_addr_decode #(
        .I_MEM_BASE (I_MEM_BASE),
        .I_MEM_SIZE (I_MEM_SIZE),
        .D_MEM_BASE (D_MEM_BASE),
        .D_MEM_SIZE (D_MEM_SIZE)
    ) u_decode (
        .adrs   (ReqAdrsQ),
        .wr     (ReqWrQ),
        .hit_i  (dec_hit_i),
        .hit_d  (dec_hit_d),
        .offset (dec_offset),
        .err    (dec_err)
    );

    // Grant qualified by ISSUE: the single cycle in which memory is actually accessed.
    assign gnt_c = (state_q == ST_ISSUE) & MemGntQ;

    // Next-state, request latch, response capture and grant-timeout counter.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rsp_d   = rsp_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (ReqValidQ) begin
                    req_d.wr     = ReqWrQ;
                    req_d.adrs   = dec_offset;
                    req_d.data   = ReqWrDataQ;
                    req_d.byteen = ReqWrQ ? ReqByteEnQ : 4'hF;
                    req_d.tag    = ReqTagQ;
                    rsp_d.data   = '0;
                    rsp_d.tag    = ReqTagQ;
                    rsp_d.err    = dec_err;
                    tgt_d        = {dec_hit_d, dec_hit_i};
                    cnt_d        = '0;
                    state_d      = dec_err ? ST_RESP : ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                rsp_d.tag = req_q.tag;
                // Grant beats the timeout when both land in the same cycle.
                if (MemGntQ) begin
                    state_d = req_q.wr ? ST_RESP : ST_RDWAIT;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_d.err = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RDWAIT: begin
                rsp_d.data = tgt_q[1] ? DMemRdDataQ : IMemRdDataQ;
                state_d    = ST_RESP;
            end

            ST_RESP: begin
                if (RspReadyQ) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any in-flight access.
    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            rsp_q   <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rsp_q   <= rsp_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake flags, response fields and memory-port drive decoded from registered state.
    always_comb begin
        ReqReadyQ   = (state_q == ST_IDLE);
        RspValidQ   = (state_q == ST_RESP);
        RspDataQ    = rsp_q.data;
        RspTagQ     = rsp_q.tag;
        RspErrQ     = rsp_q.err;
        MmioReqQ    = (state_q == ST_ISSUE);
        MmioAdrsQ   = req_q.adrs;
        MmioWrDataQ = req_q.data;
        MmioByteEnQ = req_q.byteen;
        MmioIMemRdQ = gnt_c & tgt_q[0] & ~req_q.wr;
        MmioIMemWrQ = gnt_c & tgt_q[0] &  req_q.wr;
        MmioDMemRdQ = gnt_c & tgt_q[1] & ~req_q.wr;
        MmioDMemWrQ = gnt_c & tgt_q[1] &  req_q.wr;
    end

endmodule

// File: tb/tb_mmio_mem_responder.sv
// Randomized scoreboard bench for mmio_mem_responder with a memory-map reference model.
module tb_mmio_mem_responder;

    localparam logic [31:0] I_BASE = 32'h0000_0000;
    localparam logic [31:0] I_SIZE = 32'h0000_1000;
    localparam logic [31:0] D_BASE = 32'h0040_0000;
    localparam logic [31:0] D_SIZE = 32'h0000_2000;
    localparam int          TMO    = 64;
    localparam int          I_WORDS = 1024;
    localparam int          D_WORDS = 2048;

    logic        QClk = 1'b0;
    logic        RstQnnnL = 1'b0;
    logic        ReqValidQ = 1'b0;
    logic        ReqReadyQ;
    logic        ReqWrQ = 1'b0;
    logic [31:0] ReqAdrsQ = '0;
    logic [31:0] ReqWrDataQ = '0;
    logic [3:0]  ReqByteEnQ = '0;
    logic [7:0]  ReqTagQ = '0;
    logic        RspValidQ;
    logic        RspReadyQ = 1'b1;
    logic [31:0] RspDataQ;
    logic [7:0]  RspTagQ;
    logic        RspErrQ;
    logic        MmioReqQ;
    logic        MemGntQ = 1'b0;
    logic [31:0] MmioAdrsQ;
    logic [31:0] MmioWrDataQ;
    logic [3:0]  MmioByteEnQ;
    logic        MmioDMemRdQ;
    logic        MmioDMemWrQ;
    logic        MmioIMemRdQ;
    logic        MmioIMemWrQ;
    logic [31:0] DMemRdDataQ = '0;
    logic [31:0] IMemRdDataQ = '0;

    mmio_mem_responder dut (
        .QClk(QClk), .RstQnnnL(RstQnnnL),
        .ReqValidQ(ReqValidQ), .ReqReadyQ(ReqReadyQ), .ReqWrQ(ReqWrQ),
        .ReqAdrsQ(ReqAdrsQ), .ReqWrDataQ(ReqWrDataQ), .ReqByteEnQ(ReqByteEnQ),
        .ReqTagQ(ReqTagQ),
        .RspValidQ(RspValidQ), .RspReadyQ(RspReadyQ), .RspDataQ(RspDataQ),
        .RspTagQ(RspTagQ), .RspErrQ(RspErrQ),
        .MmioReqQ(MmioReqQ), .MemGntQ(MemGntQ), .MmioAdrsQ(MmioAdrsQ),
        .MmioWrDataQ(MmioWrDataQ), .MmioByteEnQ(MmioByteEnQ),
        .MmioDMemRdQ(MmioDMemRdQ), .MmioDMemWrQ(MmioDMemWrQ),
        .MmioIMemRdQ(MmioIMemRdQ), .MmioIMemWrQ(MmioIMemWrQ),
        .DMemRdDataQ(DMemRdDataQ), .IMemRdDataQ(IMemRdDataQ)
    );

    always #5 QClk = ~QClk;

    // Expected outcome of one request. strb = {IRd, IWr, DRd, DWr}; lat/issue < 0 = unchecked.
    typedef struct {
        logic [31:0] data;
        logic [7:0]  tag;
        logic        err;
        logic [3:0]  strb;
        logic [31:0] off;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          lat;
        int          issue;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          pop_cyc = 0;
    int          gnt_mode = 3;   // 0 random, 1 never, 2 on issue cycle TMO-1, 3 always
    int          rdy_mode = 1;   // 0 random, 1 always, 2 never
    int          issue_idx = -1;

    logic [31:0] ref_i [I_WORDS];
    logic [31:0] ref_d [D_WORDS];
    logic [31:0] env_i [I_WORDS];
    logic [31:0] env_d [D_WORDS];

    logic [3:0]  strb_now;
    assign strb_now = {MmioIMemRdQ, MmioIMemWrQ, MmioDMemRdQ, MmioDMemWrQ};

    always @(posedge QClk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Reference model: window/alignment rules, grant policy and a word-array memory.
    task automatic model(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic [7:0] tag, output exp_t e);
        longint unsigned la, ib, db;
        bit in_i, in_d;
        int widx;
        la = {32'h0, a};
        ib = {32'h0, I_BASE};
        db = {32'h0, D_BASE};
        in_i = (la >= ib) && (la < ib + {32'h0, I_SIZE});
        in_d = (la >= db) && (la < db + {32'h0, D_SIZE});
        e.data = '0; e.tag = tag; e.err = 1'b0; e.strb = '0; e.off = '0;
        e.wdata = d; e.be = wr ? be : 4'hF; e.lat = -1; e.issue = -1;
        if (!(in_i || in_d) || (!wr && a[1:0] != 2'b00)) begin
            e.err = 1'b1; e.lat = 1; e.issue = 0;
            return;
        end
        e.off = in_i ? (a - I_BASE) : (a - D_BASE);
        widx = int'(e.off >> 2);
        if (gnt_mode == 1) begin
            e.err = 1'b1; e.issue = TMO;
            return;
        end
        if (in_i) begin
            e.strb = wr ? 4'b0100 : 4'b1000;
            if (wr) ref_i[widx] = merge(ref_i[widx], d, be);
            else    e.data = ref_i[widx];
        end else begin
            e.strb = wr ? 4'b0001 : 4'b0010;
            if (wr) ref_d[widx] = merge(ref_d[widx], d, be);
            else    e.data = ref_d[widx];
        end
        if (gnt_mode == 3) e.lat = wr ? 2 : 3;
        if (gnt_mode == 2) e.issue = TMO;
    endtask

    // Grant and response-ready drivers, updated just after each active edge.
    always @(posedge QClk) begin
        #1;
        if (MmioReqQ) issue_idx++; else issue_idx = -1;
        case (gnt_mode)
            0:       MemGntQ = MmioReqQ ? (issue_idx >= 40 || $urandom_range(2, 0) != 0)
                                        : 1'($urandom_range(1, 0));
            1:       MemGntQ = 1'b0;
            2:       MemGntQ = (issue_idx == TMO - 1);
            default: MemGntQ = 1'b1;
        endcase
        case (rdy_mode)
            0:       RspReadyQ = ($urandom_range(3, 0) != 0);
            1:       RspReadyQ = 1'b1;
            default: RspReadyQ = 1'b0;
        endcase
    end

    // Memory wrappers: writes land on the strobe, read data is valid only the cycle after.
    logic i_pend = 1'b0, d_pend = 1'b0;
    int   i_idx = 0, d_idx = 0;
    always @(negedge QClk) begin
        if (MmioIMemRdQ) begin i_pend = 1'b1; i_idx = int'(MmioAdrsQ[11:2]); end
        if (MmioDMemRdQ) begin d_pend = 1'b1; d_idx = int'(MmioAdrsQ[12:2]); end
        if (MmioIMemWrQ) env_i[MmioAdrsQ[11:2]] = merge(env_i[MmioAdrsQ[11:2]], MmioWrDataQ, MmioByteEnQ);
        if (MmioDMemWrQ) env_d[MmioAdrsQ[12:2]] = merge(env_d[MmioAdrsQ[12:2]], MmioWrDataQ, MmioByteEnQ);
    end
    always @(posedge QClk) begin
        #1;
        IMemRdDataQ = i_pend ? env_i[i_idx] : $urandom;
        DMemRdDataQ = d_pend ? env_d[d_idx] : $urandom;
        i_pend = 1'b0;
        d_pend = 1'b0;
    end

    // Monitor: checks memory strobes and responses against the head of the scoreboard.
    bit          vseen = 0;
    int          strobe_seen = 0;
    int          issue_seen = 0;
    logic [31:0] snap_data;
    logic [7:0]  snap_tag;
    logic        snap_err;
    always @(negedge QClk) begin
        exp_t f;
        if (!RstQnnnL) begin
            q.delete();
            vseen = 0; strobe_seen = 0; issue_seen = 0;
        end else begin
            if (MmioReqQ) issue_seen++;
            if (strb_now != 4'b0000) begin
                strobe_seen++;
                if (q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL stray_strobe: got 0x%0h with no request outstanding", strb_now);
                end else begin
                    f = q[0];
                    chk("strobe_kind", 32'(strb_now), 32'(f.strb));
                    chk("mmio_adrs", MmioAdrsQ, f.off);
                    chk("mmio_byteen", 32'(MmioByteEnQ), 32'(f.be));
                    if (f.strb[2] || f.strb[0]) chk("mmio_wrdata", MmioWrDataQ, f.wdata);
                end
            end
            if (RspValidQ) begin
                if (q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL stray_rsp: got tag 0x%02h with no request outstanding", RspTagQ);
                end else begin
                    f = q[0];
                    if (!vseen) begin
                        vseen = 1;
                        snap_data = RspDataQ; snap_tag = RspTagQ; snap_err = RspErrQ;
                        if (f.lat >= 0) chk("rsp_latency", 32'(cyc - acc_cyc), 32'(f.lat));
                    end else begin
                        chk("rsp_data_stable", RspDataQ, snap_data);
                        chk("rsp_tag_stable", 32'(RspTagQ), 32'(snap_tag));
                        chk("rsp_err_stable", 32'(RspErrQ), 32'(snap_err));
                    end
                    chk("req_ready_in_resp", 32'(ReqReadyQ), 32'd0);
                    if (RspReadyQ) begin
                        void'(q.pop_front());
                        chk("rsp_data", RspDataQ, f.data);
                        chk("rsp_tag", 32'(RspTagQ), 32'(f.tag));
                        chk("rsp_err", 32'(RspErrQ), 32'(f.err));
                        chk("strobe_count", 32'(strobe_seen), (f.strb != 4'b0000) ? 32'd1 : 32'd0);
                        if (f.issue >= 0) chk("issue_cycles", 32'(issue_seen), 32'(f.issue));
                        vseen = 0; strobe_seen = 0; issue_seen = 0;
                        pop_cyc = cyc;
                    end
                end
            end
        end
    end

    // Present one request and wait (bounded) for it to be accepted.
    task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic [7:0] tag);
        exp_t e;
        int   waited;
        waited = 0;
        @(negedge QClk);
        ReqValidQ = 1'b1; ReqWrQ = wr; ReqAdrsQ = a;
        ReqWrDataQ = d; ReqByteEnQ = be; ReqTagQ = tag;
        while (!ReqReadyQ && waited < 400) begin
            @(negedge QClk);
            waited++;
        end
        if (!ReqReadyQ) begin
            n_vec++; n_err++;
            $display("FAIL req_accept_timeout: ready still 0 after %0d cycles, required 1", waited);
            ReqValidQ = 1'b0;
            return;
        end
        model(wr, a, d, be, tag, e);
        q.push_back(e);
        acc_cyc = cyc;
        @(posedge QClk);
        #1;
        ReqValidQ = 1'b0; ReqWrQ = 1'($urandom_range(1, 0)); ReqAdrsQ = $urandom;
        ReqWrDataQ = $urandom; ReqTagQ = 8'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || !ReqReadyQ) && n < 500) begin
            @(negedge QClk);
            n++;
        end
        if (q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", q.size());
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_ready", 32'(ReqReadyQ), 32'd1);
        chk("rst_rsp_valid", 32'(RspValidQ), 32'd0);
        chk("rst_rsp_err", 32'(RspErrQ), 32'd0);
        chk("rst_mmio_req", 32'(MmioReqQ), 32'd0);
        chk("rst_strobes", 32'(strb_now), 32'd0);
        chk("rst_rsp_data", RspDataQ, 32'd0);
        chk("rst_rsp_tag", 32'(RspTagQ), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] edges [6];
        logic [31:0] a;
        logic        wr;
        logic        seen;

        for (int i = 0; i < I_WORDS; i++) begin ref_i[i] = $urandom; env_i[i] = ref_i[i]; end
        for (int i = 0; i < D_WORDS; i++) begin ref_d[i] = $urandom; env_d[i] = ref_d[i]; end
        ref_i[1] = 32'h0010_0093; env_i[1] = 32'h0010_0093;
        edges[0] = I_BASE + I_SIZE - 32'd4;
        edges[1] = I_BASE + I_SIZE;
        edges[2] = D_BASE - 32'd4;
        edges[3] = D_BASE;
        edges[4] = D_BASE + D_SIZE - 32'd4;
        edges[5] = D_BASE + D_SIZE;

        repeat (3) @(negedge QClk);
        chk_reset_vals();
        RstQnnnL = 1'b1;
        @(negedge QClk);
        chk_reset_vals();

        // Directed accesses with grant and response-ready held high.
        gnt_mode = 3; rdy_mode = 1;
        send(1'b1, 32'h0040_0010, 32'hDEAD_BEEF, 4'hF, 8'h11);
        drain();
        send(1'b0, 32'h0000_0004, 32'h0, 4'h0, 8'h22);
        drain();
        send(1'b0, 32'h0080_0000, 32'h0, 4'h0, 8'h23);
        drain();
        send(1'b0, 32'h0040_0006, 32'h0, 4'h0, 8'h24);
        drain();

        // Grant starvation: full timeout, then a grant on the last allowed cycle.
        gnt_mode = 1;
        send(1'b0, D_BASE + 32'h100, 32'h0, 4'h0, 8'h70);
        drain();
        gnt_mode = 2;
        send(1'b0, D_BASE + 32'h100, 32'h0, 4'h0, 8'h71);
        drain();
        send(1'b1, I_BASE + 32'h20, 32'h1234_5678, 4'b0101, 8'h72);
        drain();
        gnt_mode = 3;

        // Response stall with a second request queued behind it.
        rdy_mode = 2;
        send(1'b0, I_BASE + 32'h8, 32'h0, 4'h0, 8'h33);
        fork
            begin
                repeat (12) @(negedge QClk);
                rdy_mode = 1;
            end
            send(1'b1, D_BASE + 32'h44, 32'hCAFE_F00D, 4'hF, 8'h44);
        join
        chk("queued_accept_delay", 32'(acc_cyc - pop_cyc), 32'd1);
        drain();

        // Reset while the read is waiting for data.
        send(1'b0, D_BASE + 32'h40, 32'h0, 4'h0, 8'h5A);
        @(negedge QClk);
        @(posedge QClk);
        #2;
        RstQnnnL = 1'b0;
        #1;
        chk_reset_vals();
        @(negedge QClk);
        chk_reset_vals();
        @(negedge QClk);
        RstQnnnL = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge QClk);
            seen = seen | RspValidQ;
        end
        chk("no_rsp_after_reset", 32'(seen), 32'd0);

        // Randomized traffic with random grant and response backpressure.
        gnt_mode = 0; rdy_mode = 0;
        for (int n = 0; n < 200; n++) begin
            wr = 1'($urandom_range(1, 0));
            case ($urandom_range(5, 0))
                0:       a = I_BASE + ($urandom & (I_SIZE - 32'd1));
                1, 2:    a = D_BASE + ($urandom & (D_SIZE - 32'd1));
                3:       a = $urandom;
                4:       a = edges[$urandom_range(5, 0)];
                default: a = I_BASE + ($urandom & 32'h3F);
            endcase
            if (!wr && $urandom_range(3, 0) != 0) a[1:0] = 2'b00;
            send(wr, a, $urandom, 4'($urandom), 8'($urandom));
            if ($urandom_range(3, 0) == 0) repeat ($urandom_range(3, 1)) @(negedge QClk);
        end
        rdy_mode = 1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_mem_responder.md
Name: mmio_mem_responder

Overview:
- Responder end of the tile's MMIO memory-access protocol. Initiators are external agents: loader, debugger, or a fabric on another tile.
- Accepts one read/write request at a time over a valid/ready channel and decodes the address into i_mem or d_mem. It then drives the memory wrappers' MMIO-side port when the tile arbiter grants, and returns a tagged response over a second valid/ready channel.
- Sits beside core_4t in gpc_4t. Drives the MMIO leg of the core-vs-MMIO address/data/enable muxes in front of d_mem_wrap and i_mem_wrap.

Parameters:
- I_MEM_BASE, 32'h0000_0000, byte base of i_mem window.
- I_MEM_SIZE, 32'h0000_1000, i_mem window size in bytes (power of two).
- D_MEM_BASE, 32'h0040_0000, byte base of d_mem window (includes CR region).
- D_MEM_SIZE, 32'h0000_2000, d_mem window size in bytes (power of two).
- GNT_TIMEOUT, 64, maximum cycles waiting for grant before an error response.

Ports:
- QClk  in  1  clock
- RstQnnnL  in  1  asynchronous reset, active-low
- ReqValidQ  in  1  request valid
- ReqReadyQ  out  1  request accepted when ReqValidQ and ReqReadyQ are both high
- ReqWrQ  in  1  1 = write, 0 = read
- ReqAdrsQ  in  32  byte address
- ReqWrDataQ  in  32  write data
- ReqByteEnQ  in  4  write byte enables
- ReqTagQ  in  8  initiator tag
- RspValidQ  out  1  response valid
- RspReadyQ  in  1  response accepted when RspValidQ and RspReadyQ are both high
- RspDataQ  out  32  read data; 0 for writes and errors
- RspTagQ  out  8  echoed tag
- RspErrQ  out  1  decode or timeout error
- MmioReqQ  out  1  arbiter request (ISSUE state)
- MemGntQ  in  1  arbiter grant; MMIO owns memory ports this cycle
- MmioAdrsQ  out  32  offset within the selected memory (address minus base)
- MmioWrDataQ  out  32  write data to memory
- MmioByteEnQ  out  4  byte enables (4'hF on reads)
- MmioDMemRdQ / MmioDMemWrQ  out  1 each  d_mem strobes
- MmioIMemRdQ / MmioIMemWrQ  out  1 each  i_mem strobes
- DMemRdDataQ  in  32  d_mem read data, valid one cycle after the strobe
- IMemRdDataQ  in  32  i_mem read data, valid one cycle after the strobe

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE. ReqReadyQ = 1. RspValidQ, RspErrQ, MmioReqQ and all strobes = 0. RspDataQ = 0, RspTagQ = 0. Timeout counter = 0.
- Single outstanding request. ReqReadyQ = (state == IDLE).
- FSM states and transitions:
  - IDLE: on handshake, latch opcode, address, data, byte enables and tag, and decode.
    - Address hits i_mem window → ISSUE, target I.
    - Address hits d_mem window → ISSUE, target D.
    - Miss, or address not word-aligned on a read → RESP with RspErrQ = 1.
  - ISSUE: MmioReqQ = 1. Strobes are combinational: (state == ISSUE) & MemGntQ & target & opcode.
    - Grant on a write → RESP (write ack).
    - Grant on a read → RDWAIT.
    - Counter reaches GNT_TIMEOUT-1 with no grant → RESP with RspErrQ = 1.
  - RDWAIT: capture the selected read data into RspDataQ at the end of this cycle → RESP.
  - RESP: RspValidQ = 1. All response fields are held stable until RspReadyQ. On handshake → IDLE.
- Latency, assuming grant in the first ISSUE cycle and RspReadyQ high:
  - Write: request handshake at cycle T, strobe at T+1, RspValidQ at T+2.
  - Read: request handshake at T, strobe at T+1, data at T+2, RspValidQ at T+3.
- Decode: window hit = (adrs & ~(SIZE-1)) == BASE. Offset = adrs - BASE, truncated to 32 bits.
- The timeout counter clears on every entry to ISSUE and saturates; it never wraps.
- Simultaneous events:
  - Grant on the timeout cycle: the grant wins and the access is issued.
  - ReqValidQ while not IDLE: ignored (ready is low).
- A response stall on RspReadyQ blocks new requests; nothing is dropped.
- Reset mid-operation aborts the in-flight access and drops any pending response. Strobes deassert immediately with reset.

Decomposition:
- gpc_4t_pkg gains:
  - t_mmio_req struct: wr, adrs, data, byteen, tag.
  - t_mmio_rsp struct: data, tag, err.
  - t_mmio_rsp_state enum: IDLE, ISSUE, RDWAIT, RESP.
  - Window base/size localparams used by the default parameters.
- One sub-module: mmio_addr_decode, combinational, returning hit_i, hit_d, offset and err.

Test Plan:
- Write 0x0040_0010, data 0xDEAD_BEEF, byteen 4'hF, tag 0x11, grant held high → MmioDMemWrQ for one cycle with MmioAdrsQ = 0x10; response tag 0x11, err 0, data 0 at T+2.
- Read 0x0000_0004, tag 0x22, IMemRdDataQ = 0x0010_0093 on the cycle after the strobe → RspDataQ = 0x0010_0093 at T+3, err 0.
- Read 0x0080_0000 (no window hit) → no strobe ever asserts; RESP at T+1 with err 1, data 0.
- MemGntQ held low for 64 cycles → MmioReqQ high for 64 cycles, then an error response. Repeat with grant on cycle 63 → normal access.
- RspReadyQ held low for 10 cycles → RspValidQ, RspDataQ and RspTagQ stable throughout and ReqReadyQ stays 0; a queued second request is accepted the cycle after the response handshake.
- Assert RstQnnnL low during RDWAIT → next cycle all outputs at reset values and ReqReadyQ = 1; no response is emitted after reset release.
